// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, access sizes, load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // lane must already be shifted down to bit 0; size 2'b11 is treated as a word
    function automatic logic [31:0] extend_load(input logic [31:0] lane,
                                                input logic [1:0]  size,
                                                input logic        zext);
        logic [31:0] res;
        case (size)
            SZ_B:    res = zext ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    res = zext ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        return ((size == SZ_H) && low[0]) || (size[1] && (low != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_storage.sv
// Word-organised data RAM: byte write-enables, synchronous write, combinational read.
module dmem_storage
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset on purpose; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with LATENCY wait states and RV32I lane steering/extension.
// Optional DMEM_MISALIGN_ERR_EN adds rsp_err and suppresses misaligned accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          rsp_err_q;

    logic          acc_we;
    logic [2:0]    acc_f3;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [1:0]    size;
    logic          misal;
    logic          commit;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [1:0]    rd_off;
    logic [31:0]   mem_rdata;
    logic [31:0]   rsp_next;
    logic          unused_addr_bits;

    assign req_ready = (state == IDLE);

    // With no wait states the access is performed straight from the request inputs.
    assign acc_we    = (LATENCY == 0) ? req_we    : we_q;
    assign acc_f3    = (LATENCY == 0) ? req_funct3 : f3_q;
    assign acc_addr  = (LATENCY == 0) ? req_addr  : addr_q;
    assign acc_wdata = (LATENCY == 0) ? req_wdata : wdata_q;
    assign size      = acc_f3[1:0];

    assign commit = (LATENCY == 0) ? (state == IDLE && req_valid)
                                   : (state == WAIT && cnt == '0);

`ifdef DMEM_MISALIGN_ERR_EN
    assign misal   = is_misaligned(size, acc_addr[1:0]);
    assign rsp_err = rsp_err_q;
`else
    assign misal = 1'b0;
    logic unused_err;
    assign unused_err = rsp_err_q;
`endif

    assign unused_addr_bits = ^acc_addr[31:AW+2];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = acc_wdata;
        rd_off  = 2'b00;
        case (size)
            SZ_B: begin
                wr_be   = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
                rd_off  = acc_addr[1:0];
            end
            SZ_H: begin
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
                rd_off  = {acc_addr[1], 1'b0};
            end
            default: ;
        endcase
        // Reset in WAIT must leave the RAM untouched.
        if (!acc_we || misal || !commit || rst) begin
            wr_be = 4'b0000;
        end
    end

    dmem_storage #(.DEPTH_WORDS(DEPTH_WORDS)) u_storage (
        .clk   (clk),
        .be    (wr_be),
        .addr  (acc_addr[AW+1:2]),
        .wdata (wr_data),
        .rdata (mem_rdata)
    );

    assign rsp_next = (acc_we || misal) ? 32'd0
                    : extend_load(mem_rdata >> {rd_off, 3'b000}, size, acc_f3[2]);

    // Request fields are plain datapath registers; only the control path is reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_next;
                            rsp_err_q <= misal;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_next;
                        rsp_err_q <= misal;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, stall, wrap and reset-in-WAIT.
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata)
`ifdef DMEM_MISALIGN_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

`ifndef DMEM_MISALIGN_ERR_EN
    assign rsp_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check(e.name, rsp_rdata, e.rdata);
`ifdef DMEM_MISALIGN_ERR_EN
                    check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
`endif
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Waits for acceptance; returns with req_valid still high, #1 after the accepting edge.
    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check({name, "_drain"}, sb.size(), 32'd0);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input string name);
        int  n  = 0;
        bit  ok = 1'b0;
        @(posedge clk); #1;
        drive(we, f3, addr, wdata);
        sb.push_back('{exp_rd, exp_err, name});
        wait_accept(name);
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        if (ok) check({name, "_latency"}, n, LATENCY);
        else    check({name, "_rsp_timeout"}, 32'd0, 32'd1);
        wait_drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);

        do_req(1'b1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw_10");
        do_req(1'b0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10");
        do_req(1'b0, F_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb_13");
        do_req(1'b0, F_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, "lbu_13");
        do_req(1'b0, F_H,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_10");
        do_req(1'b0, F_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, "lhu_12");
        do_req(1'b1, F_B,  32'h11, 32'h000000AA, 32'h0,        1'b0, "sb_11");
        do_req(1'b0, F_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, "lw_10_sb");
        do_req(1'b1, F_H,  32'h12, 32'h00001234, 32'h0,        1'b0, "sh_12");
        do_req(1'b0, F_W,  32'h10, 32'h0,        32'h1234AAEF, 1'b0, "lw_10_sh");

        // Response stall with a second request waiting behind it.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(1'b0, F_W, 32'h10, 32'h0);
        sb.push_back('{32'h1234AAEF, 1'b0, "stall_lw"});
        sb.push_back('{32'hFFFFAAEF, 1'b0, "stall_lh"});
        wait_accept("stall_lw");
        drive(1'b0, F_H, 32'h10, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_rsp_seen", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_rdata", rsp_rdata, 32'h1234AAEF);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        check("after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_drain("stall_lh");

        // Upper address bits are ignored.
        do_req(1'b1, F_W, 32'h1000, 32'h00000055, 32'h0,        1'b0, "sw_1000");
        do_req(1'b0, F_W, 32'h0,    32'h0,        32'h00000055, 1'b0, "lw_0_wrap");

        // Reset during WAIT discards the store.
        do_req(1'b1, F_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "sw_20_prior");
        @(posedge clk); #1;
        drive(1'b1, F_W, 32'h20, 32'h00000001);
        wait_accept("sw_20_reset");
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        do_req(1'b0, F_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "lw_20_after_rst");

`ifdef DMEM_MISALIGN_ERR_EN
        do_req(1'b1, F_W, 32'h22, 32'hFFFFFFFF, 32'h0,        1'b1, "sw_22_misal");
        do_req(1'b0, F_W, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, "lw_20_unchanged");
        do_req(1'b0, F_H, 32'h21, 32'h0,        32'h0,        1'b1, "lh_21_misal");
`else
        do_req(1'b0, F_W, 32'h13, 32'h0, 32'h1234AAEF, 1'b0, "lw_13_aligned");
        do_req(1'b0, F_H, 32'h11, 32'h0, 32'hFFFFAAEF, 1'b0, "lh_11_aligned");
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
